gf_mul_seq: RTL and testbench
=============================

Name: gf_mul_seq

Overview:
- Parametrised bit-serial GF(2^M) multiplier with a valid/ready handshake on both sides; successor to the fixed GF(8) combinational multiplier.
- Field width and primitive polynomial are parameters, so one block serves the GF(8) encoder path and wider (e.g. GF(256)) RS encoder/decoder datapaths.
- Trades latency (M cycles per product) for area: one shift-and-add step per clock, MSB-first.

Parameters:
- M, 3, field width in bits (2..16); elements are M-bit polynomial-basis vectors.
- POLY, 4'b1011, primitive polynomial, width M+1, bit M must be 1 (default x^3+x+1).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands a, b present
- in_ready  output  1  block can accept operands this cycle
- a  input  M  multiplicand
- b  input  M  multiplier, scanned MSB first
- acc_mode  input  1  accumulate request, sampled with a/b (used only under GF_MUL_ACC_EN)
- out_valid  output  1  z holds a finished result
- out_ready  input  1  downstream accepts z
- z  output  M  product (or accumulated sum), registered

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk. On a rising edge with rst=1: state=IDLE, out_valid=0, z=0, internal product/count registers=0. in_ready is forced 0 while rst=1.
- States: IDLE, RUN, DONE (two-bit encoding).
- IDLE: in_ready=1. On in_valid & in_ready: latch a->a_r, b->b_r, acc_mode->m_r; prod=0; cnt=M-1; go to RUN.
- RUN: each cycle prod <= xt(prod) ^ (b_r[cnt] ? a_r : 0), where xt(x) = (x<<1)[M-1:0] ^ (x[M-1] ? POLY[M-1:0] : 0). cnt decrements.
- Leaving RUN: on the step with cnt==0, write the final value into z, set out_valid=1 and go to DONE. No new input is accepted while in RUN.
- DONE: z and out_valid are held stable until out_ready=1. On out_valid & out_ready: out_valid clears and state returns to IDLE.
- Back-to-back: in_ready = (state==IDLE) | (state==DONE & out_ready). A simultaneous out-accept and in-accept in DONE goes straight to RUN with the new operands; out_valid drops for that edge.
- Latency: operands accepted at edge k -> out_valid=1 and z valid after edge k+M. Throughput is one product per M+1 cycles with out_ready tied high.
- Zero operands still take M cycles; the result is 0.
- All arithmetic is XOR only; no carries. z never exceeds M bits.
- rst during RUN or DONE abandons the operation: no out_valid pulse, and the result is lost.
- in_valid deasserted in IDLE: no state change. a and b are don't-care unless accepted.

Optional Feature:
- Macro GF_MUL_ACC_EN.
- Defined: when the accepted m_r=1, the final write is z <= z ^ product, i.e. a GF add into the previous result (MAC for syndrome/remainder accumulation). When m_r=0, z <= product. Reset clears the accumulator (z=0).
- Undefined: acc_mode is ignored (port kept, unused), and z is always the plain product.

Test Plan:
- M=3, POLY=4'b1011: a=3, b=7, out_ready=1 -> out_valid high 3 cycles after accept, z=2; then a=2, b=5 -> z=1; exhaustive 8x8 sweep matches alpha-log reference model.
- M=8, POLY=9'h11B: a=8'h57, b=8'h83 -> z=8'hC1 after 8 cycles; a=8'h02, b=8'h80 -> z=8'h1B.
- Backpressure: out_ready=0 for 5 cycles after completion -> z and out_valid stable, in_ready=0. out_ready=1 with in_valid=1 same cycle -> new operands accepted, no lost or duplicated result.
- Reset mid-RUN (M=8, assert rst at step 4 for 1 cycle) -> out_valid=0, z=0, in_ready=1 the cycle after rst drops. The next product a=8'h57, b=8'h83 is correct.
- Boundary: a=0 or b=0 -> z=0 after M cycles; b=1 -> z=a; a=b=all-ones with M=3 -> z=3 (7*7 = alpha^10 = alpha^3).
- GF_MUL_ACC_EN, M=3: (3,7,acc=0) -> z=2; (2,5,acc=1) -> z=2^1=3; (4,4,acc=1) -> z=3^6=5. Without the macro, the same stimulus gives 2, 1, 6.

Source files
------------

// File: rtl/gf_mul_seq.sv
// Bit-serial GF(2^M) multiplier, MSB-first, M cycles per product, valid/ready on both sides.
// Optional macro GF_MUL_ACC_EN: when defined, acc_mode=1 adds the new product into the previous z.
module gf_mul_seq #(
  parameter int           M    = 3,
  parameter logic [M:0]   POLY = 4'b1011
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         acc_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] z
);

  localparam int CNT_W = (M > 2) ? $clog2(M) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [M-1:0]       a_q;
  logic [M-1:0]       b_q;
  logic [M-1:0]       prod_q;
  logic [M-1:0]       prod_d;
  logic [M-1:0]       z_q;
  logic [M-1:0]       z_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               out_valid_q;
  logic               accept;

  // Multiply by x modulo the field polynomial.
  function automatic logic [M-1:0] xt(input logic [M-1:0] x);
    xt = {x[M-2:0], 1'b0} ^ (x[M-1] ? POLY[M-1:0] : '0);
  endfunction

  // One Horner step: shift the partial product, then add a if the current b bit is set.
  function automatic logic [M-1:0] mac_step(input logic [M-1:0] p,
                                            input logic [M-1:0] x,
                                            input logic         bit_set);
    mac_step = xt(p) ^ (bit_set ? x : '0);
  endfunction

`ifdef GF_MUL_ACC_EN
  logic m_q;
`else
  logic acc_mode_unused;
  assign acc_mode_unused = acc_mode;
`endif

  assign in_ready  = ~rst & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign z         = z_q;

  always_comb begin
    prod_d = mac_step(prod_q, a_q, b_q[cnt_q]);
`ifdef GF_MUL_ACC_EN
    z_d = m_q ? (z_q ^ prod_d) : prod_d;
`else
    z_d = prod_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
`ifdef GF_MUL_ACC_EN
      m_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) state_q <= S_RUN;
        end
        S_RUN: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            z_q         <= z_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // Result is consumed; a new operand pair may be taken on the same edge.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= accept ? S_RUN : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (accept) begin
        a_q    <= a;
        b_q    <= b;
        prod_q <= '0;
        cnt_q  <= CNT_W'(M - 1);
`ifdef GF_MUL_ACC_EN
        m_q    <= acc_mode;
`endif
      end
    end
  end

endmodule

// File: tb/tb_gf_mul_seq.sv
// Self-checking bench for gf_mul_seq: GF(8) and GF(256) instances with a result scoreboard.
module tb_gf_mul_seq;

`ifdef GF_MUL_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv3, ir3, acc3, ov3, or3;
  logic [2:0] a3, b3, z3;
  logic       iv8, ir8, acc8, ov8, or8;
  logic [7:0] a8, b8, z8;

  gf_mul_seq #(.M(3), .POLY(4'b1011)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3),
    .acc_mode(acc3), .out_valid(ov3), .out_ready(or3), .z(z3));

  gf_mul_seq #(.M(8), .POLY(9'h11B)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .acc_mode(acc8), .out_valid(ov8), .out_ready(or8), .z(z8));

  int nchk = 0;
  int nerr = 0;
  logic [2:0] q3[$];
  logic [7:0] q8[$];
  logic [2:0] e3;
  logic [7:0] e8;
  int exp3[7];
  int log3[8];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       acc;
    logic [7:0] exp_plain;
    logic [7:0] exp_acc;
  } vec_t;

  vec_t t3[8];
  vec_t t8[6];

  task automatic check(input string name, input int got, input int want);
    nchk++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Independent reference: LSB-first shift-and-add with doubling of the multiplicand.
  function automatic logic [15:0] ref_mul(input int m, input logic [16:0] poly,
                                          input logic [15:0] x, input logic [15:0] y);
    logic [15:0] r, s, mask;
    r = '0;
    s = x;
    mask = (16'h1 << m) - 16'h1;
    for (int i = 0; i < m; i++) begin
      if (y[i]) r = r ^ s;
      s = ((s << 1) & mask) ^ (s[m-1] ? (poly[15:0] & mask) : 16'h0);
    end
    return r;
  endfunction

  function automatic logic [2:0] log_mul3(input logic [2:0] x, input logic [2:0] y);
    if (x == 3'd0 || y == 3'd0) return 3'd0;
    return 3'(exp3[(log3[x] + log3[y]) % 7]);
  endfunction

  // Scoreboard monitors: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst) q3.delete();
    else if (ov3 && or3) begin
      nchk++;
      if (q3.size() == 0) begin
        nerr++;
        $display("FAIL z3_unexpected got=%0h want=none", z3);
      end else begin
        e3 = q3.pop_front();
        if (z3 !== e3) begin
          nerr++;
          $display("FAIL z3_result got=%0h want=%0h", z3, e3);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) q8.delete();
    else if (ov8 && or8) begin
      nchk++;
      if (q8.size() == 0) begin
        nerr++;
        $display("FAIL z8_unexpected got=%0h want=none", z8);
      end else begin
        e8 = q8.pop_front();
        if (z8 !== e8) begin
          nerr++;
          $display("FAIL z8_result got=%0h want=%0h", z8, e8);
        end
      end
    end
  end

  // Drivers are entered just after a rising edge and return just after the accepting edge.
  task automatic send3(input logic [2:0] av, input logic [2:0] bv, input logic accv,
                       input logic [2:0] ev);
    int w;
    iv3 = 1'b1; a3 = av; b3 = bv; acc3 = accv;
    w = 0;
    forever begin
      @(negedge clk);
      if (ir3) begin q3.push_back(ev); break; end
      w++;
      if (w > 50) begin check("send3_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    iv3 = 1'b0; a3 = 3'($urandom); b3 = 3'($urandom); acc3 = 1'($urandom);
  endtask

  task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ev);
    int w;
    iv8 = 1'b1; a8 = av; b8 = bv; acc8 = 1'b0;
    w = 0;
    forever begin
      @(negedge clk);
      if (ir8) begin q8.push_back(ev); break; end
      w++;
      if (w > 50) begin check("send8_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while ((q3.size() != 0 || q8.size() != 0) && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    check(name, q3.size() + q8.size(), 0);
  endtask

  initial begin
    int lat;
    int v;
    logic [2:0] bp_z;
    logic bp_v, bp_r;

    v = 1;
    for (int i = 0; i < 7; i++) begin
      exp3[i] = v;
      log3[v] = i;
      v = v << 1;
      if (v & 8) v = v ^ 'hB;
    end

    t3[0] = '{8'd3, 8'd7, 1'b0, 8'd2, 8'd2};
    t3[1] = '{8'd2, 8'd5, 1'b1, 8'd1, 8'd3};
    t3[2] = '{8'd4, 8'd4, 1'b1, 8'd6, 8'd5};
    t3[3] = '{8'd0, 8'd5, 1'b0, 8'd0, 8'd0};
    t3[4] = '{8'd6, 8'd0, 1'b0, 8'd0, 8'd0};
    t3[5] = '{8'd5, 8'd1, 1'b0, 8'd5, 8'd5};
    t3[6] = '{8'd7, 8'd7, 1'b0, 8'd3, 8'd3};
    t3[7] = '{8'd0, 8'd0, 1'b0, 8'd0, 8'd0};

    t8[0] = '{8'h57, 8'h83, 1'b0, 8'hC1, 8'hC1};
    t8[1] = '{8'h02, 8'h80, 1'b0, 8'h1B, 8'h1B};
    t8[2] = '{8'h00, 8'hA5, 1'b0, 8'h00, 8'h00};
    t8[3] = '{8'hC3, 8'h00, 1'b0, 8'h00, 8'h00};
    t8[4] = '{8'hFF, 8'hFF, 1'b0, 8'(ref_mul(8, 17'h11B, 16'hFF, 16'hFF)), 8'h00};
    t8[5] = '{8'hA5, 8'h01, 1'b0, 8'hA5, 8'hA5};
    t8[4].exp_acc = t8[4].exp_plain;

    rst = 1'b1;
    iv3 = 1'b0; a3 = '0; b3 = '0; acc3 = 1'b0; or3 = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; acc8 = 1'b0; or8 = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready3", ir3, 0);
    check("rst_out_valid3", ov3, 0);
    check("rst_z3", z3, 0);
    check("rst_in_ready8", ir8, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("idle_in_ready3", ir3, 1);
    check("idle_out_valid8", ov8, 0);
    check("idle_z8", z8, 0);

    // GF(8) vector table, first entry also measures latency
    for (int i = 0; i < 8; i++) begin
      send3(t3[i].a[2:0], t3[i].b[2:0], t3[i].acc,
            ACC ? t3[i].exp_acc[2:0] : t3[i].exp_plain[2:0]);
      if (i == 0) begin
        lat = 0;
        while (!ov3 && lat < 20) begin @(posedge clk); #1; lat++; end
        check("latency3", lat, 3);
      end
    end

    // Exhaustive GF(8) sweep against the alpha-log model, back-to-back
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        send3(3'(x), 3'(y), 1'b0, log_mul3(3'(x), 3'(y)));
    drain("drain_sweep");

    // GF(256) vector table
    for (int i = 0; i < 6; i++) begin
      send8(t8[i].a, t8[i].b, t8[i].exp_plain);
      if (i == 0) begin
        lat = 0;
        while (!ov8 && lat < 40) begin @(posedge clk); #1; lat++; end
        check("latency8", lat, 8);
      end
    end
    drain("drain_gf256");

    // Backpressure: result held, no new input taken, then out/in handshake on the same edge
    or3 = 1'b0;
    send3(3'd3, 3'd7, 1'b0, 3'd2);
    iv3 = 1'b1; a3 = 3'd6; b3 = 3'd6;
    lat = 0;
    while (!ov3 && lat < 20) begin @(posedge clk); #1; lat++; end
    check("bp_first_valid", ov3, 1);
    for (int i = 0; i < 5; i++) begin
      bp_z = z3; bp_v = ov3; bp_r = ir3;
      check("bp_hold_z", bp_z, 2);
      check("bp_hold_valid", bp_v, 1);
      check("bp_in_ready", bp_r, 0);
      @(posedge clk); #1;
    end
    iv3 = 1'b0;
    or3 = 1'b1;
    send3(3'd2, 3'd5, 1'b0, 3'd1);
    check("bp_restart_valid_drop", ov3, 0);
    drain("drain_backpressure");

    // Reset in the middle of a GF(256) product
    send8(8'h57, 8'h83, 8'hC1);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", ov8, 0);
    check("midrst_z", z8, 0);
    check("midrst_in_ready", ir8, 1);
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      if (ov8) lat++;
      @(posedge clk); #1;
    end
    check("midrst_no_pulse", lat, 0);
    send8(8'h57, 8'h83, 8'hC1);
    send8(8'h02, 8'h80, 8'h1B);
    drain("drain_after_reset");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
